// File: rtl/acc_drain_pkg.sv
// Shared accumulator configuration and the drain-stage state type.
// Word width matches the accumulator read port: four partial sums per word.
package acc_drain_pkg;

    localparam int unsigned SUPER_SYS_COLS   = 16;
    localparam int unsigned P_BITWIDTH       = 32;
    localparam int unsigned ACC_WORD_W       = 4 * P_BITWIDTH;
    localparam int unsigned ACC_GROUPS       = SUPER_SYS_COLS / 4;
    localparam int unsigned WORD_BYTES_LOG2  = 4;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPTURE,
        WRITE,
        DONE
    } acc_drain_state_t;

endpackage

// File: rtl/acc_drain_if.sv
// Valid/ready memory write port carrying one accumulator word per beat.
// master drives the request; slave (memory) returns wr_ready.
interface acc_drain_if
    import acc_drain_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = ACC_WORD_W
);

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/acc_drain.sv
// Drains the accumulator buffers row-major after a GEMM tile, one word per
// column group, onto the memory write port; start/busy/done control.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ROW_W  = 16,
    parameter int unsigned GROUPS = ACC_GROUPS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    input  logic [ADDR_W-1:0]                row_stride,
    input  logic [ROW_W-1:0]                 num_rows,
    input  logic [2:0]                       num_groups,
    input  logic [GROUPS-1:0]                empty,
    input  logic [GROUPS-1:0][ACC_WORD_W-1:0] acc_data,
    output logic [GROUPS-1:0]                rd_en,
    acc_drain_if.master                      wr,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [2:0]  MAX_GROUPS = 3'(GROUPS);

    acc_drain_state_t state_q, state_d;

    logic [ADDR_W-1:0]     row_base_q;
    logic [ADDR_W-1:0]     stride_q;
    logic [ROW_W-1:0]      rows_q;
    logic [2:0]            groups_q;
    logic [ROW_W-1:0]      r_q;
    logic [2:0]            g_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [ACC_WORD_W-1:0] wr_data_q;
    logic                  wr_valid_c;

    logic [GW-1:0] gi;
    logic          last_group;
    logic          last_row;
    logic          empty_job;
    logic          handshake;

    assign gi         = g_q[GW-1:0];
    assign last_group = (g_q == groups_q - 3'd1);
    assign last_row   = (r_q == rows_q - ROW_W'(1));
    assign empty_job  = (num_rows == '0) || (num_groups == '0);
    assign handshake  = (state_q == WRITE) && wr.wr_ready;

    assign wr.wr_valid = wr_valid_c;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_en      = '0;
        wr_valid_c = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = empty_job ? DONE : POP;
                end
            end
            POP: begin
                busy = 1'b1;
                // Pop only a buffer that has data; otherwise wait here.
                if (!empty[gi]) begin
                    rd_en[gi] = 1'b1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                busy    = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                wr_valid_c = 1'b1;
                if (wr.wr_ready) begin
                    state_d = (last_group && last_row) ? DONE : POP;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_q <= '0;
            stride_q   <= '0;
            rows_q     <= '0;
            groups_q   <= '0;
            r_q        <= '0;
            g_q        <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                row_base_q <= base_addr;
                stride_q   <= row_stride;
                rows_q     <= num_rows;
                groups_q   <= (num_groups > MAX_GROUPS) ? MAX_GROUPS : num_groups;
                r_q        <= '0;
                g_q        <= '0;
            end
            // Read data arrives the cycle after rd_en, so it is sampled in CAPTURE.
            if (state_q == CAPTURE) begin
                wr_data_q <= acc_data[gi];
                wr_addr_q <= row_base_q + (ADDR_W'(g_q) << WORD_BYTES_LOG2);
            end
            if (handshake) begin
                if (!last_group) begin
                    g_q <= g_q + 3'd1;
                end else if (!last_row) begin
                    g_q        <= '0;
                    r_q        <= r_q + ROW_W'(1);
                    row_base_q <= row_base_q + stride_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: an accumulator buffer model feeds the DUT
// and every written word is compared with addresses/data computed per (row, group).
module tb_acc_drain;
    import acc_drain_pkg::*;

    localparam int NG = 4;
    localparam int DEPTH = 128;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          start = 1'b0;
    logic [31:0]                   base_addr = '0;
    logic [31:0]                   row_stride = '0;
    logic [15:0]                   num_rows = '0;
    logic [2:0]                    num_groups = '0;
    logic [NG-1:0]                 empty;
    logic [NG-1:0]                 empty_model;
    logic [NG-1:0]                 force_empty = '0;
    logic [NG-1:0][ACC_WORD_W-1:0] acc_data = '0;
    logic [NG-1:0]                 rd_en;
    logic                          busy;
    logic                          done;

    acc_drain_if #(.ADDR_W(32), .DATA_W(ACC_WORD_W)) wr_if ();

    acc_drain #(.ADDR_W(32), .ROW_W(16), .GROUPS(NG)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .num_rows   (num_rows),
        .num_groups (num_groups),
        .empty      (empty),
        .acc_data   (acc_data),
        .rd_en      (rd_en),
        .wr         (wr_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Accumulator buffers: words pushed by the bench, popped by rd_en, data one cycle later.
    logic [ACC_WORD_W-1:0] buf_word [NG][DEPTH];
    int unsigned buf_cnt [NG] = '{0, 0, 0, 0};
    int unsigned buf_ptr [NG] = '{0, 0, 0, 0};
    logic [NG-1:0] pend = '0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NG; i++) begin
            if (pend[i] && buf_ptr[i] < buf_cnt[i]) begin
                acc_data[i] <= buf_word[i][buf_ptr[i]];
                buf_ptr[i]  <= buf_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        empty_model = '0;
        for (int i = 0; i < NG; i++) empty_model[i] = (buf_ptr[i] >= buf_cnt[i]);
    end
    assign empty = empty_model | force_empty;

    // Observations taken mid-cycle, away from the rising edge.
    logic [31:0]           obs_addr [$];
    logic [ACC_WORD_W-1:0] obs_data [$];
    int                    hs_cyc [$];
    int                    rd_cyc_q [$];
    int unsigned           pops [NG] = '{0, 0, 0, 0};
    int                    done_cnt = 0;
    int                    done_cyc = -1;
    int                    proto_bad = 0;
    logic                  hold_prev = 1'b0;
    logic [31:0]           prev_addr = '0;
    logic [ACC_WORD_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        pend <= rd_en;
        if (!rst) begin
            if (rd_en != '0) begin
                rd_cyc_q.push_back(cyc);
                for (int i = 0; i < NG; i++) if (rd_en[i]) pops[i] <= pops[i] + 1;
                if (!$onehot(rd_en) || (rd_en & empty) != '0) proto_bad <= proto_bad + 1;
            end
            if (wr_if.wr_valid && wr_if.wr_ready) begin
                obs_addr.push_back(wr_if.wr_addr);
                obs_data.push_back(wr_if.wr_data);
                hs_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                if (busy) proto_bad <= proto_bad + 1;
            end
            if (hold_prev && (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== prev_addr ||
                              wr_if.wr_data !== prev_data))
                proto_bad <= proto_bad + 1;
        end
        hold_prev <= !rst && wr_if.wr_valid && !wr_if.wr_ready;
        prev_addr <= wr_if.wr_addr;
        prev_data <= wr_if.wr_data;
    end

    int checks = 0;
    int errors = 0;
    logic rand_ready = 1'b0;

    logic [31:0] j_base, j_stride;
    int j_rows, j_groups, j_hs0, j_done0, j_rd0, j_st;
    int unsigned j_ptr [NG];
    int unsigned j_pops [NG];

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) wr_if.wr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load(input int g, input int n);
        for (int k = 0; k < n; k++) begin
            buf_word[g][buf_cnt[g]] = {$urandom, $urandom, $urandom, $urandom};
            buf_cnt[g] = buf_cnt[g] + 1;
        end
    endtask

    task automatic begin_job(input logic [31:0] b, input logic [31:0] s,
                             input int rows, input int groups_raw);
        j_groups = (groups_raw > 4) ? 4 : groups_raw;
        j_rows   = rows;
        j_base   = b;
        j_stride = s;
        for (int g = 0; g < j_groups; g++) load(g, rows);
        tick();
        tick();
        for (int g = 0; g < NG; g++) begin
            j_ptr[g]  = buf_ptr[g];
            j_pops[g] = pops[g];
        end
        j_hs0   = obs_addr.size();
        j_done0 = done_cnt;
        j_rd0   = rd_cyc_q.size();
        base_addr  = b;
        row_stride = s;
        num_rows   = 16'(rows);
        num_groups = 3'(groups_raw);
        start = 1'b1;
        j_st  = cyc;
        tick();
        start = 1'b0;
        // Config must have been captured at start; scramble it afterwards.
        base_addr  = $urandom;
        row_stride = $urandom;
        num_rows   = 16'($urandom);
        num_groups = 3'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == j_done0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == j_done0) begin
            errors++;
            $display("FAIL %s done_timeout: no done after %0d cycles", name, budget);
        end
    endtask

    task automatic check_job(input string name);
        int exp_n = j_rows * j_groups;
        int got = obs_addr.size() - j_hs0;
        logic [31:0] ea;
        logic [ACC_WORD_W-1:0] ed;
        checks++;
        if (got != exp_n) begin
            errors++;
            $display("FAIL %s write_count got %0d exp %0d", name, got, exp_n);
        end
        for (int i = 0; i < exp_n && i < got; i++) begin
            int r = i / j_groups;
            int g = i % j_groups;
            ea = j_base + j_stride * 32'(r) + 32'(g * 16);
            ed = buf_word[g][j_ptr[g] + r];
            checks++;
            if (obs_addr[j_hs0 + i] !== ea) begin
                errors++;
                $display("FAIL %s addr[%0d] got %h exp %h", name, i, obs_addr[j_hs0 + i], ea);
            end
            checks++;
            if (obs_data[j_hs0 + i] !== ed) begin
                errors++;
                $display("FAIL %s data[%0d] got %h exp %h", name, i, obs_data[j_hs0 + i], ed);
            end
        end
        checks++;
        if (done_cnt - j_done0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses got %0d exp 1", name, done_cnt - j_done0);
        end
        for (int g = 0; g < NG; g++) begin
            int ep = (g < j_groups) ? j_rows : 0;
            checks++;
            if (int'(pops[g] - j_pops[g]) != ep) begin
                errors++;
                $display("FAIL %s pops[%0d] got %0d exp %0d", name, g, pops[g] - j_pops[g], ep);
            end
        end
        checks++;
        if (proto_bad != 0) begin
            errors++;
            $display("FAIL %s protocol_violations got %0d exp 0", name, proto_bad);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_if.wr_valid !== 1'b0 || rd_en !== '0 ||
            wr_if.wr_addr !== '0 || wr_if.wr_data !== '0) begin
            errors++;
            $display("FAIL %s outputs got busy=%b done=%b valid=%b rd_en=%b addr=%h data=%h exp all zero",
                     name, busy, done, wr_if.wr_valid, rd_en, wr_if.wr_addr, wr_if.wr_data);
        end
    endtask

    task automatic test_reset();
        wr_if.wr_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");
    endtask

    task automatic test_basic();
        begin_job(32'h1000, 32'h40, 2, 4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic busy_after_start got %b exp 1", busy);
        end
        wait_done("basic", 200);
        check_job("basic");
        checks++;
        if (rd_cyc_q.size() <= j_rd0 || rd_cyc_q[j_rd0] != j_st + 1) begin
            errors++;
            $display("FAIL basic first_pop_cycle got %0d exp %0d",
                     (rd_cyc_q.size() > j_rd0) ? rd_cyc_q[j_rd0] - j_st : -1, 1);
        end
        checks++;
        if (hs_cyc.size() <= j_hs0 || hs_cyc[j_hs0] != j_st + 3) begin
            errors++;
            $display("FAIL basic first_write_cycle got %0d exp %0d",
                     (hs_cyc.size() > j_hs0) ? hs_cyc[j_hs0] - j_st : -1, 3);
        end
        checks++;
        if (hs_cyc.size() < j_hs0 + 8 || hs_cyc[j_hs0 + 7] != j_st + 24) begin
            errors++;
            $display("FAIL basic last_write_cycle got %0d exp %0d",
                     (hs_cyc.size() >= j_hs0 + 8) ? hs_cyc[j_hs0 + 7] - j_st : -1, 24);
        end
        checks++;
        if (done_cyc != j_st + 25) begin
            errors++;
            $display("FAIL basic done_cycle got %0d exp %0d", done_cyc - j_st, 25);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic after_done got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_two_groups();
        begin_job(32'h0, $urandom & 32'hFFF0, 3, 2);
        wait_done("two_groups", 300);
        check_job("two_groups");
    endtask

    task automatic test_empty_stall();
        begin_job($urandom, $urandom, 1, 4);
        force_empty[1] = 1'b1;
        while (cyc < j_st + 8) tick();
        checks++;
        if (rd_en !== '0 || busy !== 1'b1 || wr_if.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_stall stalled got rd_en=%b busy=%b valid=%b exp 0000 1 0",
                     rd_en, busy, wr_if.wr_valid);
        end
        tick();
        force_empty[1] = 1'b0;
        wait_done("empty_stall", 200);
        check_job("empty_stall");
    endtask

    task automatic test_ready_stall();
        logic [31:0] a;
        logic [ACC_WORD_W-1:0] d;
        int n = 0;
        wr_if.wr_ready = 1'b0;
        begin_job($urandom, $urandom, 1, 2);
        while (wr_if.wr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (wr_if.wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL ready_stall valid_timeout got %b exp 1", wr_if.wr_valid);
        end
        a = wr_if.wr_addr;
        d = wr_if.wr_data;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== a || wr_if.wr_data !== d) begin
                errors++;
                $display("FAIL ready_stall hold[%0d] got valid=%b addr=%h exp valid=1 addr=%h",
                         k, wr_if.wr_valid, wr_if.wr_addr, a);
            end
        end
        wr_if.wr_ready = 1'b1;
        wait_done("ready_stall", 200);
        check_job("ready_stall");
    endtask

    task automatic test_empty_job();
        begin_job($urandom, $urandom, 0, 3);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_rows done_next_cycle got done=%b busy=%b exp 1 0", done, busy);
        end
        wait_done("empty_rows", 20);
        check_job("empty_rows");
        begin_job($urandom, $urandom, 2, 0);
        wait_done("empty_groups", 20);
        check_job("empty_groups");
        checks++;
        if (done_cyc != j_st + 1) begin
            errors++;
            $display("FAIL empty_groups done_cycle got %0d exp 1", done_cyc - j_st);
        end
    endtask

    task automatic test_start_while_busy();
        begin_job($urandom, $urandom, 2, 4);
        repeat (5) tick();
        base_addr  = $urandom;
        row_stride = $urandom;
        num_rows   = 16'd1;
        num_groups = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("start_busy", 200);
        check_job("start_busy");
        repeat (10) tick();
        checks++;
        if (done_cnt != j_done0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy extra_job got dones=%0d busy=%b exp 1 0",
                     done_cnt - j_done0, busy);
        end
    endtask

    task automatic test_wrap();
        begin_job(32'hFFFF_FFF0, $urandom, 2, 2);
        wait_done("wrap", 200);
        check_job("wrap");
        checks++;
        if (obs_addr.size() < j_hs0 + 2 || obs_addr[j_hs0 + 1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap second_addr got %h exp 00000000",
                     (obs_addr.size() >= j_hs0 + 2) ? obs_addr[j_hs0 + 1] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_reset_in_write();
        int n = 0;
        int hs0, d0;
        wr_if.wr_ready = 1'b0;
        begin_job($urandom, $urandom, 2, 4);
        while (wr_if.wr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (wr_if.wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_write valid_timeout got %b exp 1", wr_if.wr_valid);
        end
        hs0 = obs_addr.size();
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        check_idle_outputs("reset_write");
        rst = 1'b0;
        wr_if.wr_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_addr.size() != hs0 || done_cnt != d0) begin
            errors++;
            $display("FAIL reset_write dropped got writes=%0d dones=%0d exp 0 0",
                     obs_addr.size() - hs0, done_cnt - d0);
        end
        begin_job($urandom, $urandom, 2, 4);
        wait_done("reset_rerun", 200);
        check_job("reset_rerun");
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            begin_job($urandom, $urandom, $urandom_range(1, 3), $urandom_range(1, 7));
            wait_done("random", 2000);
            check_job("random");
        end
        rand_ready = 1'b0;
        wr_if.wr_ready = 1'b1;
    endtask

    initial begin
        wr_if.wr_ready = 1'b1;
        test_reset();
        test_basic();
        test_two_groups();
        test_empty_stall();
        test_ready_stall();
        test_empty_job();
        test_start_while_busy();
        test_wrap();
        test_reset_in_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_drain.md
# acc_drain

Result write-back stage directly downstream of the accumulator. After a GEMM tile completes, it drains the four accumulator buffers in row-major order, one 128-bit word (four P_BITWIDTH partial sums) per column group. Each word goes out on a valid/ready memory write port with addresses generated from a base address and row stride. The RISC-V side sees it as a start/busy/done engine.

## Interface
Parameters:
- ADDR_W, 32, byte address width of memory write port
- ROW_W, 16, width of row count
- GROUPS, SUPER_SYS_COLS/4, number of accumulator buffers drained (4)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches the config inputs when idle
- base_addr  in  ADDR_W  byte address of row 0, group 0
- row_stride  in  ADDR_W  byte distance between consecutive result rows
- num_rows  in  ROW_W  rows to drain
- num_groups  in  3  column groups per row, 1..4
- empty  in  GROUPS  per-buffer empty flags from accumulator
- acc_data  in  GROUPS x 128  per-buffer read data from accumulator
- rd_en  out  GROUPS  one-hot pop strobe to accumulator
- wr_valid  out  1  write request valid
- wr_addr  out  ADDR_W  write byte address
- wr_data  out  128  write data
- wr_ready  in  1  memory accepts when wr_valid && wr_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of drain

## Operation
- States: IDLE, POP, CAPTURE, WRITE, DONE.
- IDLE: busy=0. On start, latch base_addr into row_base, row_stride, num_rows, and num_groups. A num_groups value above 4 is clamped to 4. Clear row counter r and group counter g.
  - If num_rows==0 or num_groups==0, go to DONE.
  - Otherwise go to POP.
- POP: if !empty[g], assert rd_en[g] for this cycle only and go to CAPTURE. Otherwise stay and keep rd_en=0.
- CAPTURE: accumulator data is valid one cycle after rd_en. Register acc_data[g] into wr_data. Set wr_addr = row_base + (g<<4), mod 2^ADDR_W. Go to WRITE.
- WRITE: wr_valid=1. wr_addr and wr_data stay stable until wr_ready is seen. On handshake:
  - If g < num_groups-1: g++, go to POP.
  - Else if r == num_rows-1: go to DONE.
  - Else: g=0, r++, row_base += row_stride (wrap mod 2^ADDR_W), go to POP.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- start is ignored while not in IDLE. Config inputs are sampled only on an accepted start.
- At most one rd_en bit is ever high. rd_en is never asserted for a buffer whose empty flag is high.

## Timing
- Reset values: state IDLE; rd_en=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0.
- busy rises the cycle after the start cycle.
- Minimum cost is 3 cycles per word (POP, CAPTURE, WRITE) with buffers non-empty and wr_ready=1.
- First wr_valid appears 3 cycles after start when empty[0]=0.
- done pulses the cycle after the final write handshake. For an empty job it pulses the cycle after start.
- Reset asserted mid-drain returns to IDLE next edge with all outputs at reset values. Any in-flight write is dropped with no handshake; a word already popped is lost.
- wr_ready arriving while wr_valid=0 has no effect.

## Structure
- Config package holds SUPER_SYS_COLS and P_BITWIDTH. Add to it an acc_drain_state_t enum for the state type.
- Word width (4×P_BITWIDTH=128) is a package constant shared with the accumulator.
- Single flat module; no sub-module needed. Address arithmetic is inline.

## Test plan
- Reset, then start with base=0x1000, stride=0x40, rows=2, groups=4, all buffers preloaded, wr_ready=1:
  - writes go to 0x1000, 0x1010, 0x1020, 0x1030, 0x1040, 0x1050, 0x1060, 0x1070 in order, carrying the popped data;
  - done pulses once; 24 cycles from first POP to last handshake.
- groups=2, rows=3, base=0: only rd_en[0]/rd_en[1] ever fire. Addresses are 0x0, 0x10, stride, stride+0x10, and so on.
- empty[1] held high 5 cycles mid-row: FSM stalls in POP with rd_en=0, then resumes. No duplicate or skipped word.
- wr_ready low 4 cycles during WRITE: wr_valid, wr_addr and wr_data stay stable; exactly one handshake occurs.
- Edge cases:
  - rows=0: done one cycle after start, no rd_en.
  - start pulsed while busy: ignored.
  - base=0xFFFFFFF0, groups=2: second address wraps to 0x0.
- rst asserted in WRITE: next cycle state IDLE, wr_valid=0, busy=0. A new start then runs a full drain correctly.
